uart_tx_fifo: RTL and testbench

Buffered UART transmit path for the ZXUNO UART (wifi module) registers. The CPU-side register logic pushes bytes with a one-cycle strobe into an internal FIFO. A serializer drains the FIFO as 8N1 frames on `tx`, gated by an optional CTS handshake from the module. This block replaces the single-byte, busy-waited transmit path and complements the existing 8 KB receive FIFO.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_fifo_sync.sv | 69 ++++++
 rtl/uart_tx_fifo.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg: shared UART types, ZXUNO register map and baud helper.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [7:0] UARTDATA = 8'hC6;
  localparam logic [7:0] UARTSTAT = 8'hC7;

  function automatic int calc_period(input int clk_hz, input int bps);
    return clk_hz / bps;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_fifo_sync: single-clock show-ahead FIFO with level/full/empty.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push & ~full_q;
    do_pop   = pop & ~empty_q;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
    full_d   = (level_d == LW'(DEPTH));
    empty_d  = (level_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_fifo: buffered 8N1 transmitter with CTS gating, overflow.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK   = 28000000,
  parameter int BPS   = 115200,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             wr_data,
  input  logic                   wr_en,
  input  logic                   cts_n,
  input  logic                   ovf_clr,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   txbusy,
  output logic                   ovf,
  output logic                   tx
);

  localparam int             PERIOD  = calc_period(CLK, BPS);
  localparam int             CW      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(PERIOD - 1);

  tx_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;
  logic        cts_meta_q, cts_meta_d;
  logic        cts_sync_q, cts_sync_d;
  logic        pop;
  logic        cts_ok;
  logic [7:0]  head;

  uart_fifo_sync #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign cts_ok = ~cts_sync_q;

  always_comb begin
    cts_meta_d = cts_n;
    cts_sync_d = cts_meta_q;
    ovf_d      = ovf_q;
    if (ovf_clr)         ovf_d = 1'b0;
    if (wr_en && full)   ovf_d = 1'b1;

    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    pop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!empty && cts_ok) begin
          pop     = 1'b1;
          shreg_d = head;
          cnt_d   = CNT_MAX;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          cnt_d    = CNT_MAX;
          bitcnt_d = 3'd7;
          tx_d     = shreg_q[0];
          state_d  = ST_DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_MAX;
          if (bitcnt_q == 3'd0) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            shreg_d  = shreg_q >> 1;
            tx_d     = shreg_q[1];
            bitcnt_d = bitcnt_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          // Chain straight into the next start bit so frames abut.
          if (!empty && cts_ok) begin
            pop     = 1'b1;
            shreg_d = head;
            cnt_d   = CNT_MAX;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      ovf_q      <= 1'b0;
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      ovf_q      <= ovf_d;
      cts_meta_q <= cts_meta_d;
      cts_sync_q <= cts_sync_d;
    end
  end

  assign tx     = tx_q;
  assign ovf    = ovf_q;
  assign txbusy = ~empty | (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       cts_n;
  logic       ovf_clr;
  logic       full, empty, txbusy, ovf, tx;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.CLK(16), .BPS(1), .DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .cts_n   (cts_n),
    .ovf_clr (ovf_clr),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .txbusy  (txbusy),
    .ovf     (ovf),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level c clocks after a start bit begins (16 clocks per bit).
  function automatic logic exp_bit(input logic [7:0] b, input int c);
    int k;
    k = c / 16;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; cts_n = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    checks++; if (tx !== 1'b1)     begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
    checks++; if (level !== 3'd0)  begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0)   begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (txbusy !== 1'b0) begin errors++; $display("FAIL reset_txbusy got %b exp 0", txbusy); end
    checks++; if (ovf !== 1'b0)    begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx !== 1'b1 || txbusy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_100 got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_single();
    int bad;
    wr_data = 8'h55; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b exp 0", empty); end
    checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL single_pre_tx got %b exp 1", tx); end
    tick();
    checks++; if (tx !== 1'b0)    begin errors++; $display("FAIL single_start got %b exp 0", tx); end
    bad = 0;
    for (int c = 0; c < 160; c++) begin
      if (tx !== exp_bit(8'h55, c)) bad++;
      if (c == 159 && txbusy !== 1'b1) bad++;
      tick();
    end
    checks++; if (bad != 0)       begin errors++; $display("FAIL single_frame got %0d bad samples exp 0", bad); end
    checks++; if (txbusy !== 1'b0) begin errors++; $display("FAIL single_txbusy_end got %b exp 0", txbusy); end
  endtask

  function automatic logic exp_burst(input int c);
    logic [7:0] b;
    b = 8'(c / 160 + 1);
    return exp_bit(b, c % 160);
  endfunction

  task automatic test_burst_ovf();
    int bad;
    logic [2:0] peak;
    bad = 0; peak = 3'd0;
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'(i + 1);
      tick();
      if (level > peak) peak = level;
      if (i >= 1 && tx !== exp_burst(i - 1)) bad++;
    end
    wr_en = 1'b0;
    checks++; if (peak !== 3'd4)  begin errors++; $display("FAIL burst_peak got %0d exp 4", peak); end
    checks++; if (ovf !== 1'b1)   begin errors++; $display("FAIL burst_ovf got %b exp 1", ovf); end
    checks++; if (full !== 1'b1)  begin errors++; $display("FAIL burst_full got %b exp 1", full); end
    for (int c = 5; c < 800; c++) begin
      tick();
      if (tx !== exp_burst(c)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL burst_frames got %0d bad samples exp 0", bad); end
    tick();
    checks++; if (txbusy !== 1'b0 || tx !== 1'b1)
      begin errors++; $display("FAIL burst_drained got txbusy=%b tx=%b exp 0/1", txbusy, tx); end
    checks++; if (ovf !== 1'b1)   begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL ovf_clr got %b exp 0", ovf); end
  endtask

  task automatic test_cts();
    int bad;
    cts_n = 1'b1;
    tick(); tick(); tick();
    wr_data = 8'hA3; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx !== 1'b1) bad++;
    end
    checks++; if (bad != 0)       begin errors++; $display("FAIL cts_hold got %0d bad cycles exp 0", bad); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL cts_level got %0d exp 1", level); end
    cts_n = 1'b0;
    tick(); tick();
    checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL cts_early got %b exp 1", tx); end
    tick();
    checks++; if (tx !== 1'b0)    begin errors++; $display("FAIL cts_start got %b exp 0", tx); end
    bad = 0;
    for (int c = 0; c < 160; c++) begin
      if (tx !== exp_bit(8'hA3, c)) bad++;
      if (c == 5)  begin wr_data = 8'h3C; wr_en = 1'b1; end
      if (c == 6)  wr_en = 1'b0;
      if (c == 40) cts_n = 1'b1;
      tick();
    end
    checks++; if (bad != 0)       begin errors++; $display("FAIL cts_frame got %0d bad samples exp 0", bad); end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx !== 1'b1) bad++;
      tick();
    end
    checks++; if (bad != 0)       begin errors++; $display("FAIL cts_wait got %0d bad cycles exp 0", bad); end
    checks++; if (level !== 3'd1 || txbusy !== 1'b1)
      begin errors++; $display("FAIL cts_queued got level=%0d txbusy=%b exp 1/1", level, txbusy); end
    cts_n = 1'b0;
    tick(); tick(); tick();
    bad = 0;
    for (int c = 0; c < 160; c++) begin
      if (tx !== exp_bit(8'h3C, c)) bad++;
      tick();
    end
    checks++; if (bad != 0 || txbusy !== 1'b0)
      begin errors++; $display("FAIL cts_release got %0d bad txbusy=%b exp 0/0", bad, txbusy); end
  endtask

  task automatic test_reset_mid();
    int bad;
    wr_en = 1'b1;
    wr_data = 8'hFF; tick();
    wr_data = 8'h11; tick();
    wr_data = 8'h22; tick();
    wr_data = 8'h33; tick();
    wr_en = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
    tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
    checks++; if (level !== 3'd3 || tx !== 1'b1)
      begin errors++; $display("FAIL mid_pre got level=%0d tx=%b exp 3/1", level, tx); end
    rst_n = 1'b0;
    tick();
    checks++; if (tx !== 1'b1 || level !== 3'd0 || empty !== 1'b1)
      begin errors++; $display("FAIL mid_reset got tx=%b level=%0d empty=%b exp 1/0/1", tx, level, empty); end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx !== 1'b1 || txbusy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_after got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_simultaneous();
    int bad;
    cts_n = 1'b1;
    tick(); tick(); tick();
    wr_data = 8'h5A; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL simul_pre got %0d exp 1", level); end
    cts_n = 1'b0;
    tick(); tick();
    wr_data = 8'hC3; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    checks++; if (level !== 3'd1 || tx !== 1'b0)
      begin errors++; $display("FAIL simul_level got level=%0d tx=%b exp 1/0", level, tx); end
    bad = 0;
    for (int c = 0; c < 320; c++) begin
      if (tx !== ((c < 160) ? exp_bit(8'h5A, c) : exp_bit(8'hC3, c - 160))) bad++;
      tick();
    end
    checks++; if (bad != 0)        begin errors++; $display("FAIL simul_order got %0d bad samples exp 0", bad); end
    checks++; if (txbusy !== 1'b0) begin errors++; $display("FAIL simul_done got %b exp 0", txbusy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_ovf();
    test_cts();
    test_reset_mid();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
